// File: rtl/wash_pkg.sv
// Shared definitions for the wash sequencer: state encodings, phase durations,
// motor pattern boundaries and BCD helpers.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5,
        ST_PAUSE = 3'd6
    } state_e;

    localparam logic [7:0] DUR_FILL        = 8'h04;
    localparam logic [7:0] DUR_RINSE       = 8'h10;
    localparam logic [7:0] DUR_SPIN        = 8'h06;
    localparam logic [7:0] DUR_DONE        = 8'h05;
    localparam logic [7:0] DEFAULT_SETTING = 8'h20;

    localparam logic [3:0] PAT_FWD_END  = 4'd5;
    localparam logic [3:0] PAT_GAP1_END = 4'd7;
    localparam logic [3:0] PAT_REV_END  = 4'd13;
    localparam logic [3:0] PAT_GAP2_END = 4'd15;

    // Setting increment: 99 wraps to 01, never 00.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = 8'h01;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic state_e next_phase(input state_e s);
        state_e r;
        case (s)
            ST_FILL:  r = ST_WASH;
            ST_WASH:  r = ST_RINSE;
            ST_RINSE: r = ST_SPIN;
            ST_SPIN:  r = ST_DONE;
            default:  r = ST_IDLE;
        endcase
        return r;
    endfunction

    // IDLE shows the setting, so its "duration" is the setting too.
    function automatic logic [7:0] phase_duration(input state_e s, input logic [7:0] setting);
        logic [7:0] r;
        case (s)
            ST_FILL:  r = DUR_FILL;
            ST_RINSE: r = DUR_RINSE;
            ST_SPIN:  r = DUR_SPIN;
            ST_DONE:  r = DUR_DONE;
            default:  r = setting;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_down2.sv
// Two-digit BCD down counter with load priority over decrement, plus a
// flag for count==01.
module bcd_down2
    import wash_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = DEFAULT_SETTING
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] count,
    output logic       is_one
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec) begin
            if (count_q[3:0] == 4'd0)
                count_d = {count_q[7:4] - 4'd1, 4'd9};
            else
                count_d = {count_q[7:4], count_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= RESET_VAL;
        else
            count_q <= count_d;
    end

    assign count  = count_q;
    assign is_one = (count_q == 8'h01);

endmodule

// File: rtl/wash_sequencer.sv
// Washing machine program sequencer: FILL/WASH/RINSE/SPIN/DONE timed on a
// 1 Hz tick, with emergency pause/resume and an adjustable wash duration.
module wash_sequencer
    import wash_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       emergency,
    input  logic       add,
    output logic       zheng,
    output logic       fan,
    output logic       alarm,
    output logic [7:0] remain,
    output logic [2:0] phase,
    output logic       busy
);

    state_e     state_q, state_d;
    state_e     saved_q, saved_d;
    logic [7:0] setting_q, setting_d;
    logic [3:0] pat_q, pat_d;
    logic       zheng_q, zheng_d;
    logic       fan_q, fan_d;
    logic       alarm_q, alarm_d;
    logic       busy_q, busy_d;

    logic       cnt_load, cnt_dec, cnt_is_one;
    logic [7:0] cnt_val, cnt_count;

    bcd_down2 #(.RESET_VAL(DEFAULT_SETTING)) u_remain (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        setting_d = setting_q;
        pat_d     = pat_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = setting_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FILL;
                    cnt_load = 1'b1;
                    cnt_val  = DUR_FILL;
                end else begin
                    if (add)
                        setting_d = bcd_inc_wrap(setting_q);
                    cnt_load = 1'b1;
                    cnt_val  = setting_d;
                end
            end
            ST_PAUSE: begin
                if (emergency)
                    state_d = saved_q;
            end
            default: begin
                // Emergency outranks a coincident tick; DONE ignores emergency.
                if (emergency && state_q != ST_DONE) begin
                    saved_d = state_q;
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (cnt_is_one) begin
                        state_d  = next_phase(state_q);
                        pat_d    = '0;
                        cnt_load = 1'b1;
                        cnt_val  = phase_duration(state_d, setting_q);
                    end else begin
                        cnt_dec = 1'b1;
                        pat_d   = (pat_q == PAT_GAP2_END) ? '0 : pat_q + 4'd1;
                    end
                end
            end
        endcase

        zheng_d = 1'b0;
        fan_d   = 1'b0;
        if (state_d == ST_SPIN)
            zheng_d = 1'b1;
        else if (state_d == ST_WASH || state_d == ST_RINSE) begin
            zheng_d = (pat_d <= PAT_FWD_END);
            fan_d   = (pat_d > PAT_GAP1_END) && (pat_d <= PAT_REV_END);
        end
        alarm_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            saved_q   <= ST_IDLE;
            setting_q <= DEFAULT_SETTING;
            pat_q     <= '0;
            zheng_q   <= 1'b0;
            fan_q     <= 1'b0;
            alarm_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            setting_q <= setting_d;
            pat_q     <= pat_d;
            zheng_q   <= zheng_d;
            fan_q     <= fan_d;
            alarm_q   <= alarm_d;
            busy_q    <= busy_d;
        end
    end

    assign zheng  = zheng_q;
    assign fan    = fan_q;
    assign alarm  = alarm_q;
    assign busy   = busy_q;
    assign remain = cnt_count;
    assign phase  = state_q;

endmodule
